part_sram_sync: RTL and testbench
=================================

// Module: part_sram_sync
// PURPOSE
//  Parametrised synchronous single-port SRAM; successor to the 4k x 1 asynchronous
//  part. Generalised word width, depth and read latency. Adds a request/ready
//  handshake, a pipelined read-valid strobe and a hardware clear sequence after reset.
//  Used for CADR control/dispatch/map memories that move onto the synchronous clock.
// PARAMETERS
//  AW       12  address width; depth = 2**AW words
//  DW       1   data word width, bits (1..64)
//  RD_LAT   1   read latency, cycles from accept to rvalid (1..4)
//  CLR_VAL  0   value written to every word during the clear sequence (DW bits)
// PORTS
//  clk        in   1   sole clock; all state on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  req        in   1   access request; qualified by ready
//  we         in   1   1 = write, 0 = read (sampled with req)
//  addr       in   AW  word address
//  wdata      in   DW  write data
//  ready      out  1   1 = block accepts req this cycle
//  rdata      out  DW  read data, valid only while rvalid = 1
//  rvalid     out  1   one-cycle strobe per accepted read
//  err        out  1   one-cycle strobe: req dropped (req while ready = 0)
//  par_err    out  1   (SRAM_PARITY_EN only) parity mismatch on the current rvalid word
//  par_inj    in   1   (SRAM_PARITY_EN only) store an inverted parity bit with this write
// BEHAVIOUR
//  - Reset (reset_n = 0, async): ready = 0, rvalid = 0, err = 0, rdata = 0, par_err = 0;
//    read pipeline flushed; FSM -> CLEAR with clear pointer = 0.
//  - FSM CLEAR: writes CLR_VAL (correct parity when enabled) to word ptr; ptr++ each
//    cycle; ready = 0. After word 2**AW-1 is written -> IDLE. Takes exactly 2**AW cycles.
//  - FSM IDLE: ready = 1 continuously; one access accepted per cycle when req = 1.
//  - Write: accepted at edge N; the word is updated at edge N. No response strobe.
//  - Read: accepted at edge N; rvalid = 1 and rdata = mem[addr] during the cycle after
//    edge N+RD_LAT-1 (RD_LAT = 1 -> the cycle right after acceptance). Fully pipelined:
//    back-to-back reads give back-to-back rvalid in issue order.
//  - Read-after-write to the same address on consecutive cycles returns the new data.
//  - Reads use the array value at the accept edge (read-before-write is impossible:
//    single port, one op per cycle).
//  - rdata holds its last value when rvalid = 0. A read of an unwritten word returns
//    CLR_VAL.
//  - err pulses one cycle after any cycle with req = 1 and ready = 0 (e.g. during CLEAR);
//    that request is discarded with no memory side effect.
//  - Reset mid-operation: in-flight reads produce no rvalid; contents are overwritten by
//    the new CLEAR pass. Reset during CLEAR restarts the pass at word 0.
//  - Address range is always in bounds (2**AW words, no wrap logic); the clear pointer
//    stops at the top word and does not wrap.
//  - No X propagation is allowed on rdata or rvalid after reset is released.
// CONFIGURATION
//  SRAM_PARITY_EN defined: each word stores one extra even-parity bit computed from
//    wdata (inverted when par_inj = 1). par_err = 1 together with rvalid when the stored
//    parity does not match rdata, else 0. The par_err and par_inj ports exist.
//  SRAM_PARITY_EN undefined: no parity storage, and the par_err and par_inj ports are
//    absent. Timing and all other behaviour are identical.
// TESTING
//  1 Clear: AW=4. Release reset; ready = 0 for exactly 16 cycles, then 1. Reading all
//    16 words returns CLR_VAL.
//  2 Write/read: DW=8, RD_LAT=2. Write 0xA5 to addr 3, then read addr 3 on the next
//    cycle -> rvalid 2 cycles after accept with rdata = 0xA5.
//  3 Pipelining: issue reads of addr 0,1,2 on consecutive cycles after writing 0x11,
//    0x22, 0x33 -> three consecutive rvalid cycles carrying 0x11, 0x22, 0x33.
//  4 Dropped request: assert req/we with addr 5 and data 0xFF during CLEAR -> err
//    pulses for one cycle; a later read of addr 5 returns CLR_VAL.
//  5 Reset mid-read: accept a read with RD_LAT=3, assert reset_n = 0 after 1 cycle ->
//    no rvalid; ready = 0 and a full CLEAR follows.
//  6 Parity (SRAM_PARITY_EN): write 0x0F with par_inj = 1, then read it -> rvalid with
//    par_err = 1. Write again with par_inj = 0 and read -> par_err = 0.

Source files
------------

// File: rtl/part_sram_sync.sv
// -----------------------------------------------------------------------------
// part_sram_sync
// Parametrised synchronous single-port SRAM with a request/ready handshake,
// a pipelined read-valid strobe and a hardware clear pass after reset.
//
// Parameters
//   AW       address width, depth = 2**AW words
//   DW       data word width in bits
//   RD_LAT   cycles from read accept to rvalid (1..4)
//   CLR_VAL  value written to every word by the clear pass
//
// Ports
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   req      access request, taken only when ready = 1
//   we       1 = write, 0 = read
//   addr     word address
//   wdata    write data
//   ready    block accepts req this cycle
//   rdata    read data, valid while rvalid = 1, holds otherwise
//   rvalid   one-cycle strobe per accepted read
//   err      one-cycle strobe one cycle after a req that met ready = 0
//   par_err  (SRAM_PARITY_EN) parity mismatch on the current rvalid word
//   par_inj  (SRAM_PARITY_EN) store inverted parity with this write
//
// Optional feature macro: SRAM_PARITY_EN (adds one even-parity bit per word).
// -----------------------------------------------------------------------------
module part_sram_sync #(
    parameter int unsigned    AW      = 12,
    parameter int unsigned    DW      = 1,
    parameter int unsigned    RD_LAT  = 1,
    parameter logic [DW-1:0]  CLR_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          err
`ifdef SRAM_PARITY_EN
    ,
    output logic          par_err,
    input  logic          par_inj
`endif
);

    localparam int unsigned DEPTH = 32'd1 << AW;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Even parity over one data word.
    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   clr_ptr_r;
    logic            ready_r;
    logic            err_r;
    logic            accept_s;
    logic            rd_fire_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [DW-1:0]   mem_wdata_s;
    logic [DW-1:0]   rd_word_s;
    logic [DW-1:0]   mem_r [DEPTH];

    logic [RD_LAT-1:0] pipe_vld_r;
    logic [DW-1:0]     pipe_data_r [RD_LAT];
    logic [RD_LAT-1:0] stg_vld_in_s;
    logic [DW-1:0]     stg_data_in_s [RD_LAT];

`ifdef SRAM_PARITY_EN
    logic              mem_wpar_s;
    logic              rd_perr_s;
    logic              par_mem_r [DEPTH];
    logic [RD_LAT-1:0] pipe_perr_r;
    logic [RD_LAT-1:0] stg_perr_in_s;
`endif

    // ready is registered, so it is a clean indicator of the IDLE state.
    assign accept_s  = req & ready_r;
    assign rd_fire_s = accept_s & ~we;
    assign rd_word_s = mem_r[addr];

    // State register, clear pointer, ready and dropped-request strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {AW{1'b0}};
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // Pointer stops on the top word; the FSM leaves CLEAR on the same edge.
            if ((state_r == ST_CLEAR) && (clr_ptr_r != {AW{1'b1}})) begin
                clr_ptr_r <= clr_ptr_r + AW'(1'b1);
            end else begin
                clr_ptr_r <= clr_ptr_r;
            end
            ready_r <= (state_nxt_s == ST_IDLE);
            err_r   <= req & ~ready_r;
        end
    end

    // Next-state logic: one full clear pass, then IDLE until the next reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == {AW{1'b1}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_IDLE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_CLEAR;
        endcase
    end

    // Array write port control: clear pass owns the port in CLEAR.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = addr;
        mem_wdata_s = wdata;
`ifdef SRAM_PARITY_EN
        mem_wpar_s  = even_par(wdata) ^ par_inj;
`endif
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = clr_ptr_r;
                mem_wdata_s = CLR_VAL;
`ifdef SRAM_PARITY_EN
                mem_wpar_s  = even_par(CLR_VAL);
`endif
            end
            ST_IDLE: begin
                mem_we_s = accept_s & we;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Storage array (no reset; the clear pass initialises it).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
`ifdef SRAM_PARITY_EN
            par_mem_r[mem_addr_s] <= mem_wpar_s;
`endif
        end
    end

`ifdef SRAM_PARITY_EN
    assign rd_perr_s = even_par(rd_word_s) ^ par_mem_r[addr];
`endif

    // Read pipeline stage inputs: stage 0 samples the array at the accept edge.
    always_comb begin
        stg_vld_in_s[0]  = rd_fire_s;
        stg_data_in_s[0] = rd_word_s;
`ifdef SRAM_PARITY_EN
        stg_perr_in_s[0] = rd_perr_s;
`endif
        for (int k = 1; k < int'(RD_LAT); k++) begin
            stg_vld_in_s[k]  = pipe_vld_r[k-1];
            stg_data_in_s[k] = pipe_data_r[k-1];
`ifdef SRAM_PARITY_EN
            stg_perr_in_s[k] = pipe_perr_r[k-1];
`endif
        end
    end

    // Read pipeline registers; data only moves with a valid so rdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int k = 0; k < int'(RD_LAT); k++) begin
                pipe_data_r[k] <= {DW{1'b0}};
            end
`ifdef SRAM_PARITY_EN
            pipe_perr_r <= {RD_LAT{1'b0}};
`endif
        end else begin
            pipe_vld_r <= stg_vld_in_s;
            for (int k = 0; k < int'(RD_LAT); k++) begin
                if (stg_vld_in_s[k]) begin
                    pipe_data_r[k] <= stg_data_in_s[k];
                end else begin
                    pipe_data_r[k] <= pipe_data_r[k];
                end
            end
`ifdef SRAM_PARITY_EN
            pipe_perr_r <= stg_vld_in_s & stg_perr_in_s;
`endif
        end
    end

    assign ready  = ready_r;
    assign err    = err_r;
    assign rvalid = pipe_vld_r[RD_LAT-1];
    assign rdata  = pipe_data_r[RD_LAT-1];
`ifdef SRAM_PARITY_EN
    assign par_err = pipe_perr_r[RD_LAT-1];
`endif

endmodule

// File: tb/tb_part_sram_sync.sv
module tb_part_sram_sync;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RD_LAT = 2;
    localparam logic [7:0] CLR = 8'h5A;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          err;
`ifdef SRAM_PARITY_EN
    logic          par_err;
    logic          par_inj = 1'b0;
`endif

    int total_cnt = 0;
    int pass_cnt = 0;

    part_sram_sync #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CLR_VAL(CLR)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err)
`ifdef SRAM_PARITY_EN
        , .par_err(par_err), .par_inj(par_inj)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       exp_rvalid;
        logic       chk_rdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with ready = 0 after reset release (bounded); optionally
    // drops one write to addr 5 during the clear pass.
    task automatic count_clear(input bit inject, output int n, output int errs, output int rvs);
        n = 0; errs = 0; rvs = 0;
        while (ready !== 1'b1 && n < 40) begin
            n++;
            if (inject && n == 3) begin
                req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'hFF;
            end else begin
                req = 1'b0; we = 1'b0;
            end
            cyc();
            if (err === 1'b1) errs++;
            if (rvalid === 1'b1) rvs++;
        end
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        req = 1'b1; we = 1'b0; addr = a;
        cyc();
        req = 1'b0;
        check({name, " rvalid early"}, 64'(rvalid), 64'd0);
        cyc();
        check({name, " rvalid"}, 64'(rvalid), 64'd1);
        check({name, " rdata"}, 64'(rdata), 64'(exp));
    endtask

`ifdef SRAM_PARITY_EN
    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic inj);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; par_inj = inj;
        cyc();
        req = 1'b0; we = 1'b0; par_inj = 1'b0;
    endtask
`endif

    initial begin
        int n, errs, rvs;

        // Table: reads of all 16 words, then write/read, pipelining, hold.
        for (int i = 0; i < 16; i++)
            vq.push_back('{1'b1, 1'b0, 4'(i), 8'h00, (i > 0), (i > 0), CLR});
        vq.push_back('{1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b1, CLR});   // rvalid for addr 15
        vq.push_back('{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00}); // read-after-write
        vq.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hA5});
        vq.push_back('{1'b1, 1'b1, 4'd0, 8'h11, 1'b0, 1'b1, 8'hA5}); // rdata holds
        vq.push_back('{1'b1, 1'b1, 4'd1, 8'h22, 1'b0, 1'b0, 8'h00});
        vq.push_back('{1'b1, 1'b1, 4'd2, 8'h33, 1'b0, 1'b0, 8'h00});
        vq.push_back('{1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00});
        vq.push_back('{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b1, 8'h11});
        vq.push_back('{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 8'h22});
        vq.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'h33});
        vq.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'h33});
        vq.push_back('{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 8'h00});
        vq.push_back('{1'b1, 1'b1, 4'd5, 8'hC3, 1'b1, 1'b1, CLR});
        vq.push_back('{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 8'h00});
        vq.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 8'hC3});
        vq.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 8'hC3});

        // Reset state.
        cyc(); cyc();
        check("reset ready", 64'(ready), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);

        // Reset during CLEAR restarts the pass.
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("partial clear ready", 64'(ready), 64'd0);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        count_clear(1'b1, n, errs, rvs);
        check("clear cycles", 64'(n), 64'd16);
        check("clear err pulses", 64'(errs), 64'd1);
        check("clear rvalid", 64'(rvs), 64'd0);
        check("ready after clear", 64'(ready), 64'd1);

        // Table-driven vectors.
        for (int i = 0; i < vq.size(); i++) begin
            req = vq[i].req; we = vq[i].we; addr = vq[i].addr; wdata = vq[i].wdata;
            cyc();
            check($sformatf("vec%0d rvalid", i), 64'(rvalid), 64'(vq[i].exp_rvalid));
            check($sformatf("vec%0d ready", i), 64'(ready), 64'd1);
            check($sformatf("vec%0d err", i), 64'(err), 64'd0);
            if (vq[i].chk_rdata)
                check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vq[i].exp_rdata));
        end
        req = 1'b0; we = 1'b0;

`ifdef SRAM_PARITY_EN
        do_write(4'd7, 8'h0F, 1'b1);
        req = 1'b1; we = 1'b0; addr = 4'd7;
        cyc(); req = 1'b0; cyc();
        check("par inj rvalid", 64'(rvalid), 64'd1);
        check("par inj par_err", 64'(par_err), 64'd1);
        cyc();
        check("par_err drops", 64'(par_err), 64'd0);
        do_write(4'd7, 8'h0F, 1'b0);
        req = 1'b1; we = 1'b0; addr = 4'd7;
        cyc(); req = 1'b0; cyc();
        check("par ok rvalid", 64'(rvalid), 64'd1);
        check("par ok par_err", 64'(par_err), 64'd0);
        check("par ok rdata", 64'(rdata), 64'h0F);
`endif

        // Reset with a read in flight: no rvalid, full clear, contents restored.
        req = 1'b1; we = 1'b0; addr = 4'd3;
        cyc();
        req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrd rvalid", 64'(rvalid), 64'd0);
        check("midrd ready", 64'(ready), 64'd0);
        check("midrd rdata", 64'(rdata), 64'd0);
        rvs = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rvalid !== 1'b0) rvs++;
        end
        reset_n = 1'b1;
        count_clear(1'b0, n, errs, rvs);
        check("midrd rvalid seen", 64'(rvs), 64'd0);
        check("midrd clear cycles", 64'(n), 64'd16);
        do_read(4'd3, CLR, "post-reset addr3");
        do_read(4'd0, CLR, "post-reset addr0");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
